digit_timer_top: RTL and testbench
==================================

DIGIT_TIMER_TOP -- requirements
Module: digit_timer_top

Interface
REQ-001 SHALL have parameter TICKS_PER_SECOND, default 10: number of enabled clk cycles per one-second tick (the hardware build overrides it with the board clock frequency).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port enable, input, 1 bit: 1 = timer runs, 0 = timer frozen.
REQ-005 SHALL have port userDigitTEN, input, 4 bits: user-selected tens digit (BCD).
REQ-006 SHALL have port userDigitONE, input, 4 bits: user-selected ones digit (BCD).
REQ-007 SHALL have port timerReconfigTEN_ONE, input, 1 bit: active-low reload pushbutton; idle level is 1.
REQ-008 SHALL have port timerCountTEN, output, 4 bits: current tens digit (BCD).
REQ-009 SHALL have port timerCountONE, output, 4 bits: current ones digit (BCD).
REQ-010 SHALL have port uno_second_timeout, output, 1 bit: one-cycle pulse marking each one-second tick.
REQ-011 SHALL have port timeOutCTRL, output, 1 bit: sticky flag, 1 = countdown has expired.

Function
REQ-012 Tick generator SHALL hold a prescale counter 0..TICKS_PER_SECOND-1 that increments only while enable=1.
REQ-013 uno_second_timeout SHALL be 1 for exactly one cycle when the prescale counter wraps from TICKS_PER_SECOND-1 to 0, and 0 otherwise.
REQ-014 While enable=0, the prescale counter SHALL hold its value and uno_second_timeout SHALL be 0.
REQ-015 Button handling SHALL register timerReconfigTEN_ONE each cycle and detect a press as a 1->0 transition (previous sample 1, current sample 0).
REQ-016 Each press SHALL produce exactly one load, regardless of how long the button is held low.
REQ-017 On a load, the counters SHALL take userDigitTEN/userDigitONE on the next edge; any digit value >9 SHALL be clamped to 9.
REQ-018 A load SHALL clear timeOutCTRL, set an internal armed flag, and restart the prescale counter at 0.
REQ-019 A load SHALL take effect independent of enable.
REQ-020 Countdown: on each uno_second_timeout while armed and the count is not 00, the two-digit BCD value SHALL decrement by 1.
REQ-021 On decrement, if ONE>0 then ONE SHALL decrement; otherwise ONE SHALL become 9 and TEN SHALL decrement (borrow).
REQ-022 Counts SHALL never go below 00, and no digit SHALL ever take a non-BCD value (above 9).
REQ-023 Expiry: when armed and count==00, timeOutCTRL SHALL go to 1 on the following edge and armed SHALL clear.
REQ-024 Because of REQ-023, loading 00 SHALL assert timeOutCTRL one cycle after the load.
REQ-025 timeOutCTRL SHALL stay 1 until rst or the next load.
REQ-026 After expiry, further ticks SHALL leave the counts at 00.
REQ-027 If a load and a tick occur in the same cycle, the load SHALL win and that tick SHALL be ignored.
REQ-028 Deasserting enable mid-count SHALL freeze the count and the prescale phase; reasserting it SHALL resume from the frozen point.
REQ-029 The design SHALL be fully synchronous, with no latches and no combinational path from inputs to outputs except through registers.

Reset
REQ-030 When rst=1 at a rising clk edge, the following SHALL all be cleared: timerCountTEN=0, timerCountONE=0, timeOutCTRL=0, uno_second_timeout=0, prescale counter=0, armed=0.
REQ-031 During reset, the button sampler SHALL be set to 1 (idle), so a button already held low at reset release does not generate a load.
REQ-032 rst SHALL override load, tick and enable.
REQ-033 Reset asserted mid-countdown SHALL abort the countdown; no timeout SHALL be produced until a new load arms the timer.

Verification
REQ-034 rst=1 for one cycle, then idle -> counts 00, timeOutCTRL=0, no ticks while enable=0.
REQ-035 enable=1, TICKS_PER_SECOND=10 -> uno_second_timeout pulses once every 10 cycles, each pulse one cycle wide.
REQ-036 user digits 2,2; press button (low for 2 cycles), press again -> count 22 after each press; sequence 22,21,20,19,...,01,00 on successive ticks; timeOutCTRL=1 one cycle after reaching 00, and it stays 1.
REQ-037 mid-count rst, reload 22 -> countdown restarts from 22 with timeOutCTRL=0; enable dropped at 12 -> count holds at 12 and no ticks until enable returns.
REQ-038 user digits 15,3 loaded -> count 93; user digits 0,0 loaded -> timeOutCTRL=1 on the next cycle.
REQ-039 button held low for 50 cycles -> exactly one load; count keeps decrementing while the button is held.

Source files
------------

// File: rtl/digit_timer_top.sv
`default_nettype none
// ============================================================================
// Module      : digit_timer_top
// Description : Two-digit BCD countdown timer with a one-second tick
//               prescaler, a debounced-by-edge reload pushbutton and a
//               sticky expiry flag.
//
// Ports
//   clk                  in   system clock, all state on rising edge
//   rst                  in   synchronous active-high reset
//   enable               in   1 = prescaler/countdown runs, 0 = frozen
//   userDigitTEN  [3:0]  in   tens digit to load (values >9 clamp to 9)
//   userDigitONE  [3:0]  in   ones digit to load (values >9 clamp to 9)
//   timerReconfigTEN_ONE in   active-low reload button, idle high
//   timerCountTEN [3:0]  out  current tens digit (BCD)
//   timerCountONE [3:0]  out  current ones digit (BCD)
//   uno_second_timeout   out  one-cycle pulse per one-second tick
//   timeOutCTRL          out  sticky flag, countdown has expired
//
// Revision    : 1.0 - initial release
// ============================================================================
module digit_timer_top #(
    parameter int TICKS_PER_SECOND = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] userDigitTEN,
    input  logic [3:0] userDigitONE,
    input  logic       timerReconfigTEN_ONE,
    output logic [3:0] timerCountTEN,
    output logic [3:0] timerCountONE,
    output logic       uno_second_timeout,
    output logic       timeOutCTRL
);

    // Prescale counter width; at least one bit so a degenerate
    // TICKS_PER_SECOND of 1 still elaborates.
    localparam int C_PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [C_PW-1:0] C_LAST = C_PW'(TICKS_PER_SECOND - 1);
    localparam logic [3:0]      C_NINE = 4'd9;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_PW-1:0] r_presc;
    logic            r_uno;
    logic [3:0]      r_ten;
    logic [3:0]      r_one;
    logic            r_tmo;
    logic            r_armed;
    logic            r_btn_s;   // current button sample
    logic            r_btn_p;   // previous button sample

    // Next-state
    logic [C_PW-1:0] w_presc;
    logic            w_uno;
    logic [3:0]      w_ten;
    logic [3:0]      w_one;
    logic            w_tmo;
    logic            w_armed;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_press;
    logic       w_wrap;
    logic       w_zero;
    logic [3:0] w_ten_clamp;
    logic [3:0] w_one_clamp;

    // A press is a falling edge between two registered samples, so a held
    // button only ever yields one load.
    assign w_press     = r_btn_p & ~r_btn_s;
    assign w_wrap      = enable && (r_presc == C_LAST);
    assign w_zero      = (r_ten == 4'd0) && (r_one == 4'd0);
    assign w_ten_clamp = (userDigitTEN > C_NINE) ? C_NINE : userDigitTEN;
    assign w_one_clamp = (userDigitONE > C_NINE) ? C_NINE : userDigitONE;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_presc = r_presc;
        w_uno   = 1'b0;
        w_ten   = r_ten;
        w_one   = r_one;
        w_tmo   = r_tmo;
        w_armed = r_armed;

        if (w_press) begin
            // Load beats a coincident tick: the prescaler restarts and the
            // tick that would have fired this cycle is dropped.
            w_presc = '0;
            w_ten   = w_ten_clamp;
            w_one   = w_one_clamp;
            w_tmo   = 1'b0;
            w_armed = 1'b1;
        end else begin
            if (enable) begin
                w_presc = w_wrap ? '0 : (r_presc + C_PW'(1));
            end
            w_uno = w_wrap;

            if (r_armed && w_zero) begin
                // Reaching (or loading) 00 expires on the following edge,
                // independent of the tick.
                w_tmo   = 1'b1;
                w_armed = 1'b0;
            end else if (r_armed && w_wrap) begin
                if (r_one != 4'd0) begin
                    w_one = r_one - 4'd1;
                end else begin
                    // Borrow; TEN is non-zero here because the count is not 00.
                    w_one = C_NINE;
                    w_ten = r_ten - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_uno   <= 1'b0;
            r_ten   <= 4'd0;
            r_one   <= 4'd0;
            r_tmo   <= 1'b0;
            r_armed <= 1'b0;
            // Samplers reset to the idle level so a button already held low
            // when reset releases is not seen as a press.
            r_btn_s <= 1'b1;
            r_btn_p <= 1'b1;
        end else begin
            r_presc <= w_presc;
            r_uno   <= w_uno;
            r_ten   <= w_ten;
            r_one   <= w_one;
            r_tmo   <= w_tmo;
            r_armed <= w_armed;
            r_btn_s <= timerReconfigTEN_ONE;
            r_btn_p <= r_btn_s;
        end
    end

    assign timerCountTEN      = r_ten;
    assign timerCountONE      = r_one;
    assign uno_second_timeout = r_uno;
    assign timeOutCTRL        = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_digit_timer_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_timer_top
// Description : Self-checking bench for digit_timer_top. Expected counts are
//               queued when a countdown is started and compared against the
//               displayed count on every one-second pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_timer_top;

    localparam int C_TPS = 10;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] userDigitTEN;
    logic [3:0] userDigitONE;
    logic       timerReconfigTEN_ONE;
    logic [3:0] timerCountTEN;
    logic [3:0] timerCountONE;
    logic       uno_second_timeout;
    logic       timeOutCTRL;

    digit_timer_top #(
        .TICKS_PER_SECOND(C_TPS)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .userDigitTEN         (userDigitTEN),
        .userDigitONE         (userDigitONE),
        .timerReconfigTEN_ONE (timerReconfigTEN_ONE),
        .timerCountTEN        (timerCountTEN),
        .timerCountONE        (timerCountONE),
        .uno_second_timeout   (uno_second_timeout),
        .timeOutCTRL          (timeOutCTRL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_ticks  = 0;
    logic [7:0] sb_q[$];          // expected count at each upcoming tick
    logic [7:0] exp_hold = 8'h00; // expected count for ticks beyond the queue
    logic       r_prev_uno = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cur_count();
        return {timerCountTEN, timerCountONE};
    endfunction

    // Push the decimal sequence (from-1) down to 'to' as BCD.
    task automatic push_down(input int from, input int to);
        for (int v = from - 1; v >= to; v--) begin
            sb_q.push_back(8'(((v / 10) * 16) + (v % 10)));
        end
    endtask

    // Tick monitor: scoreboard compare and pulse-width check.
    always @(negedge clk) begin
        if (uno_second_timeout === 1'b1) begin
            logic [7:0] exp;
            n_ticks++;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : exp_hold;
            check_value("tick_count", 32'(cur_count()), 32'(exp));
            check_value("tick_width", 32'(r_prev_uno), 32'd0);
        end
        r_prev_uno <= uno_second_timeout;
    end

    task automatic wait_count(input logic [7:0] val, input int limit,
                              output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (cur_count() == val) begin
                cyc = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick(input int limit, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (uno_second_timeout) begin
                cyc = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    // Press for two cycles; report the count and flag on the cycle the load
    // lands, then release for one cycle.
    task automatic press_load(input logic [3:0] ten, input logic [3:0] one,
                              output logic [7:0] seen, output logic tmo);
        userDigitTEN         = ten;
        userDigitONE         = one;
        timerReconfigTEN_ONE = 1'b0;
        repeat (2) @(negedge clk);
        seen = cur_count();
        tmo  = timeOutCTRL;
        timerReconfigTEN_ONE = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        bit         ok;
        int         t0;
        logic [7:0] seen;
        logic       tmo;

        rst                  = 1'b1;
        enable               = 1'b0;
        userDigitTEN         = 4'd0;
        userDigitONE         = 4'd0;
        timerReconfigTEN_ONE = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset state and idle with enable low
        check_value("rst_count", 32'(cur_count()), 32'h00);
        check_value("rst_tmo", 32'(timeOutCTRL), 32'd0);
        check_value("rst_uno", 32'(uno_second_timeout), 32'd0);
        t0 = n_ticks;
        repeat (30) @(negedge clk);
        check_value("idle_no_ticks", 32'(n_ticks - t0), 32'd0);

        // Tick period with enable high
        enable = 1'b1;
        wait_tick(40, cyc, ok);
        check_value("first_tick_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_tick(40, cyc, ok);
            check_value("tick_period", 32'(cyc), 32'(C_TPS));
        end
        check_value("unarmed_tmo", 32'(timeOutCTRL), 32'd0);

        // Load 22 twice, then full countdown to expiry
        enable = 1'b0;
        repeat (2) @(negedge clk);
        press_load(4'd2, 4'd2, seen, tmo);
        check_value("load22_a", 32'(seen), 32'h22);
        press_load(4'd2, 4'd2, seen, tmo);
        check_value("load22_b", 32'(seen), 32'h22);
        push_down(22, 0);
        exp_hold = 8'h00;
        enable   = 1'b1;
        wait_count(8'h00, 300, cyc, ok);
        check_value("reach_00", 32'(ok), 32'd1);
        check_value("tmo_at_00", 32'(timeOutCTRL), 32'd0);
        @(negedge clk);
        check_value("tmo_after_00", 32'(timeOutCTRL), 32'd1);
        repeat (30) @(negedge clk);
        check_value("tmo_sticky", 32'(timeOutCTRL), 32'd1);
        check_value("hold_00", 32'(cur_count()), 32'h00);
        check_value("sb_drained_1", 32'(sb_q.size()), 32'd0);

        // Mid-count reset, reload, freeze/resume
        enable = 1'b0;
        repeat (2) @(negedge clk);
        press_load(4'd2, 4'd2, seen, tmo);
        check_value("reload22", 32'(seen), 32'h22);
        check_value("reload_clr_tmo", 32'(tmo), 32'd0);
        push_down(22, 19);
        enable = 1'b1;
        wait_count(8'h19, 100, cyc, ok);
        check_value("reach_19", 32'(ok), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value("midrst_count", 32'(cur_count()), 32'h00);
        check_value("midrst_tmo", 32'(timeOutCTRL), 32'd0);
        repeat (40) @(negedge clk);
        check_value("midrst_no_tmo", 32'(timeOutCTRL), 32'd0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        press_load(4'd2, 4'd2, seen, tmo);
        check_value("restart22", 32'(seen), 32'h22);
        check_value("restart_tmo", 32'(tmo), 32'd0);
        push_down(22, 12);
        exp_hold = 8'h12;
        enable   = 1'b1;
        wait_count(8'h12, 200, cyc, ok);
        check_value("reach_12", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);  // prescaler now 4 into its second
        enable = 1'b0;
        t0 = n_ticks;
        repeat (50) @(negedge clk);
        check_value("freeze_count", 32'(cur_count()), 32'h12);
        check_value("freeze_no_ticks", 32'(n_ticks - t0), 32'd0);
        push_down(12, 11);
        enable = 1'b1;
        wait_count(8'h11, 40, cyc, ok);
        check_value("resume_latency", 32'(cyc), 32'd6);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Clamp and zero loads
        press_load(4'd15, 4'd3, seen, tmo);
        check_value("clamp_ten", 32'(seen), 32'h93);
        press_load(4'd3, 4'd12, seen, tmo);
        check_value("clamp_one", 32'(seen), 32'h39);
        press_load(4'd0, 4'd0, seen, tmo);
        check_value("load00_count", 32'(seen), 32'h00);
        check_value("load00_tmo_at_load", 32'(tmo), 32'd0);
        check_value("load00_tmo_next", 32'(timeOutCTRL), 32'd1);
        press_load(4'd0, 4'd0, seen, tmo);
        check_value("reload00_clears", 32'(tmo), 32'd0);
        check_value("reload00_tmo_next", 32'(timeOutCTRL), 32'd1);

        // Long hold: exactly one load, countdown continues under the hold
        userDigitTEN         = 4'd2;
        userDigitONE         = 4'd2;
        timerReconfigTEN_ONE = 1'b0;
        repeat (2) @(negedge clk);
        check_value("hold_load22", 32'(cur_count()), 32'h22);
        push_down(22, 15);
        exp_hold = 8'h15;
        enable   = 1'b1;
        repeat (48) @(negedge clk);
        check_value("hold_decrementing", 32'(cur_count() < 8'h22), 32'd1);
        timerReconfigTEN_ONE = 1'b1;
        wait_count(8'h15, 100, cyc, ok);
        check_value("hold_reach_15", 32'(ok), 32'd1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_value("sb_drained_2", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
